v2k_typedef_yee_pack: RTL and testbench

Byte-to-pixel packer directly upstream of v2k_typedef_yee_sub1.
- Accepts a serial 8-bit component stream (R, G, B order) with a valid/ready handshake.
- Assembles pixel24_t words and buffers them in a small FIFO.
- Presents them on a valid/ready output whose data port drives sub1_in_pixel.
- Also reports frame-alignment errors and counts pixels delivered per frame.

---
 rtl/v2k_typedef_yee_inc.sv | 15 +
 rtl/v2k_typedef_yee_pix_fifo.sv | 66 ++++++
 rtl/v2k_typedef_yee_pack.sv | 111 +++++++++++
 tb/tb_v2k_typedef_yee_pack.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/v2k_typedef_yee_inc.sv
// Shared types for the yee pixel path: byte/pixel types and the packer phase enum.
package v2k_typedef_yee_inc;

   typedef logic       logic_t;
   typedef logic [7:0] byte_t;

   typedef struct packed {
      byte_t r;
      byte_t g;
      byte_t b;
   } pixel24_t;

   typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

endpackage

// File: rtl/v2k_typedef_yee_pix_fifo.sv
// Circular pixel FIFO; head holds the last popped pixel while empty.
module v2k_typedef_yee_pix_fifo
   import v2k_typedef_yee_inc::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                        cp,
   input  logic                        reset,
   input  logic                        push,
   input  pixel24_t                    push_data,
   input  logic                        pop,
   output pixel24_t                    head,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [AW-1:0] PtrOne = AW'(1);
   localparam logic [CW-1:0] CntOne = CW'(1);
   localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

   pixel24_t          mem_q [FIFO_DEPTH];
   pixel24_t          last_q;
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push, do_pop;

   assign full    = (count_q == DepthC);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? last_q : mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge cp or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         last_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + PtrOne;
         end
         if (do_pop) begin
            last_q   <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/v2k_typedef_yee_pack.sv
// Byte-to-pixel packer: R,G,B byte stream in, buffered pixel24_t stream out,
// with frame-alignment error pulse and per-frame delivered-pixel count.
module v2k_typedef_yee_pack
   import v2k_typedef_yee_inc::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             cp,
   input  logic             reset,
   input  logic [7:0]       in_byte,
   input  logic             in_valid,
   input  logic             in_sof,
   output logic             in_ready,
   output logic [23:0]      out_pixel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err_short,
   output logic [CNT_W-1:0] pix_count
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   phase_t           phase_q, phase_d;
   byte_t            r_q, r_d, g_q, g_d;
   logic             err_q, err_d;
   logic             run_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_acc, out_acc, push, full, empty;
   logic [CW-1:0]    fifo_count;
   pixel24_t         push_pix, head;

   // run_q keeps in_ready low while reset is held and for the release edge.
   assign in_ready  = run_q & (fifo_count < DepthC);
   assign out_valid = ~empty;
   assign in_acc    = in_valid & in_ready;
   assign out_acc   = out_valid & out_ready;
   assign out_pixel = head;
   assign err_short = err_q;
   assign pix_count = cnt_q;
   assign push      = in_acc & ~in_sof & (phase_q == PH_B) & ~full;
   assign push_pix  = '{r: r_q, g: g_q, b: in_byte};

   always_comb begin
      phase_d = phase_q;
      r_d     = r_q;
      g_d     = g_q;
      err_d   = 1'b0;
      if (in_acc) begin
         if (in_sof) begin
            // SOF always restarts the pixel; any partial pixel is dropped.
            r_d     = in_byte;
            phase_d = PH_G;
            err_d   = (phase_q != PH_R);
         end else begin
            unique case (phase_q)
               PH_R: begin
                  r_d     = in_byte;
                  phase_d = PH_G;
               end
               PH_G: begin
                  g_d     = in_byte;
                  phase_d = PH_B;
               end
               default: phase_d = PH_R;
            endcase
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (in_acc & in_sof) cnt_d = '0;
      else if (out_acc)    cnt_d = cnt_q + CntOne;
   end

   always_ff @(posedge cp or negedge reset) begin
      if (!reset) begin
         phase_q <= PH_R;
         r_q     <= '0;
         g_q     <= '0;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         phase_q <= phase_d;
         r_q     <= r_d;
         g_q     <= g_d;
         err_q   <= err_d;
         run_q   <= 1'b1;
         cnt_q   <= cnt_d;
      end
   end

   v2k_typedef_yee_pix_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .cp        (cp),
      .reset     (reset),
      .push      (push),
      .push_data (push_pix),
      .pop       (out_acc),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_v2k_typedef_yee_pack.sv
// Bench for the byte-to-pixel packer: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based model.
module tb_v2k_typedef_yee_pack;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNTW  = 4;

   logic            cp = 1'b0;
   logic            reset = 1'b0;
   logic [7:0]      in_byte = '0;
   logic            in_valid = 1'b0;
   logic            in_sof = 1'b0;
   logic            in_ready;
   logic [23:0]     out_pixel;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            err_short;
   logic [CNTW-1:0] pix_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 cp = ~cp;

   v2k_typedef_yee_pack #(
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (CNTW)
   ) dut (
      .cp        (cp),
      .reset     (reset),
      .in_byte   (in_byte),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_ready  (in_ready),
      .out_pixel (out_pixel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_short (err_short),
      .pix_count (pix_count)
   );

   // Behavioural model: pixels as a queue, partial pixel as a byte list.
   logic [23:0] m_q[$];
   logic [7:0]  m_part[$];
   logic [23:0] m_last;
   bit          m_run, m_err;
   int          m_cnt;

   function automatic bit m_in_ready();
      return m_run && (m_q.size() < DEPTH);
   endfunction

   always @(posedge cp or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         m_part.delete();
         m_last = '0;
         m_run  = 0;
         m_err  = 0;
         m_cnt  = 0;
      end else begin
         bit ia, oa;
         ia = in_valid && m_in_ready();
         oa = (m_q.size() > 0) && out_ready;
         m_err = 0;
         if (oa) begin
            m_last = m_q.pop_front();
            m_cnt  = (m_cnt + 1) % (1 << CNTW);
         end
         if (ia) begin
            if (in_sof) begin
               m_err = (m_part.size() != 0);
               m_part.delete();
               m_cnt = 0;
            end
            m_part.push_back(in_byte);
            if (m_part.size() == 3) begin
               m_q.push_back({m_part[0], m_part[1], m_part[2]});
               m_part.delete();
            end
         end
         m_run = 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model.
   always @(negedge cp) begin
      check("in_ready",  32'(in_ready),  32'(m_in_ready()));
      check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      check("out_pixel", 32'(out_pixel), 32'(m_q.size() > 0 ? m_q[0] : m_last));
      check("err_short", 32'(err_short), 32'(m_err));
      check("pix_count", 32'(pix_count), 32'(m_cnt));
   end

   // Drive one byte at a negedge and hold it until accepted (bounded).
   task automatic send(input logic [7:0] b, input logic s);
      bit acc = 0;
      in_valid = 1'b1;
      in_byte  = b;
      in_sof   = s;
      for (int n = 0; n < 50; n++) begin
         acc = in_ready;
         @(negedge cp);
         if (acc) break;
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge cp);
   endtask

   initial begin
      bit held_rdy;
      // Reset state.
      @(negedge cp);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_pixel", 32'(out_pixel), 32'd0);
      check("rst_pix_count", 32'(pix_count), 32'd0);
      reset = 1'b1;
      @(negedge cp);
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // Basic pixel and latency.
      out_ready = 1'b1;
      send(8'h11, 1'b1);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_pixel", 32'(out_pixel), 32'h112233);
      @(negedge cp);
      check("t1_count", 32'(pix_count), 32'd1);
      check("t1_empty", 32'(out_valid), 32'd0);

      // Backpressure: two pixels fill the FIFO, the seventh byte stalls.
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
      check("t2_full_rdy", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_byte  = 8'h07;
      idle(3);
      check("t2_stall_rdy", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge cp);
      check("t2_rdy_rise", 32'(in_ready), 32'd1);
      send(8'h07, 1'b0);
      send(8'h08, 1'b0);
      send(8'h09, 1'b0);
      idle(4);
      check("t2_count", 32'(pix_count), 32'd4);

      // Short pixel on SOF.
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(8'hCC, 1'b1);
      check("t3_err", 32'(err_short), 32'd1);
      send(8'hDD, 1'b0);
      check("t3_err_clr", 32'(err_short), 32'd0);
      send(8'hEE, 1'b0);
      check("t3_pixel", 32'(out_pixel), 32'hCCDDEE);

      // SOF accepted in the same cycle as a pop: clear wins.
      for (int i = 0; i < 4; i++) begin
         send(8'h50, 1'b0);
         send(8'h51, 1'b0);
         send(8'h52, 1'b0);
      end
      idle(2);
      check("t4_pre", 32'(pix_count), 32'd5);
      out_ready = 1'b0;
      send(8'h60, 1'b0);
      send(8'h61, 1'b0);
      send(8'h62, 1'b0);
      out_ready = 1'b1;
      send(8'h70, 1'b1);
      check("t4_clear", 32'(pix_count), 32'd0);
      send(8'h71, 1'b0);
      send(8'h72, 1'b0);
      idle(2);

      // Counter wrap: 17 pixels in one frame on a 4-bit counter.
      for (int p = 0; p < 17; p++) begin
         send(8'(p), p == 0);
         send(8'h5A, 1'b0);
         send(8'hA5, 1'b0);
      end
      idle(3);
      check("t5_wrap", 32'(pix_count), 32'd1);

      // Reset mid-pixel with a pixel buffered.
      out_ready = 1'b0;
      send(8'h01, 1'b1);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      send(8'h05, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("t6_valid", 32'(out_valid), 32'd0);
      check("t6_count", 32'(pix_count), 32'd0);
      check("t6_rdy",   32'(in_ready),  32'd0);
      @(negedge cp);
      reset = 1'b1;
      @(negedge cp);
      out_ready = 1'b1;
      send(8'h31, 1'b0);
      send(8'h32, 1'b0);
      send(8'h33, 1'b0);
      check("t6_pixel", 32'(out_pixel), 32'h313233);
      idle(2);

      // Random traffic; inputs held while stalled.
      held_rdy = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (!(in_valid && !held_rdy)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_byte  = 8'($urandom);
            in_sof   = ($urandom_range(0, 15) == 0);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         held_rdy  = in_ready;
         @(negedge cp);
      end
      in_valid = 1'b0;
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
